native_mem_slave: RTL and testbench

//   Word-addressed RAM slave on the PicoRV32 native memory bus (valid/ready).

---
 rtl/native_mem_slave_if.sv | 24 ++
 rtl/native_mem_slave.sv | 179 +++++++++++++++++
 tb/tb_native_mem_slave.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/native_mem_slave_if.sv
// PicoRV32 native memory bus bundle between the core (master) and a memory slave.
`timescale 1ns/1ps
interface native_mem_slave_if;
  // Handshake: the master raises mem_valid with addr/wdata/wstrb/instr stable and
  // holds it until it sees mem_ready; mem_ready is a one-cycle completion strobe,
  // mem_rdata is valid only while mem_ready is high, and mem_wstrb==0 means read.
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/native_mem_slave.sv
// Word-addressed RAM slave for the PicoRV32 native bus with programmable latency,
// optional LFSR stall injection, a tohost mailbox, OOB flagging and counters.
`timescale 1ns/1ps
module native_mem_slave #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned STALL_EN    = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000,
  parameter logic [31:0] OOB_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                resetn,
  native_mem_slave_if.slave   bus,
  input  logic                load_we,
  input  logic [15:0]         load_addr,
  input  logic [31:0]         load_data,
  output logic                tohost_valid,
  output logic [31:0]         tohost_data,
  output logic                err_oob,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         store_cnt,
  output logic [1:0]          fsm_state
);

  localparam int          AW       = $clog2(MEM_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit          STALL_ON = (STALL_EN != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        accept;
  logic        stall;

  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_instr;

  logic        ready_q;
  logic [31:0] rdata_q;

  logic [29:0]   req_word;
  logic [AW-1:0] ram_idx;
  logic [AW-1:0] load_idx;
  logic          is_tohost;
  logic          in_ram;
  logic          is_write;
  logic          complete;
  logic [31:0]   byte_mask;
  logic          unused_addr_bits;

  logic [31:0] ram [MEM_WORDS];

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign fsm_state     = state;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign stall    = STALL_ON && lfsr[0];

  // Decode works on the latched request so mid-wait bus changes cannot leak in.
  assign req_word         = req_addr[31:2];
  assign unused_addr_bits = ^req_addr[1:0];
  assign ram_idx          = req_word[AW-1:0];
  assign load_idx         = AW'(load_addr);
  assign is_tohost        = (req_word == TOHOST_ADDR[31:2]);
  assign in_ram           = ({2'b00, req_word} < 32'(MEM_WORDS));
  assign is_write         = |req_wstrb;
  assign complete         = (state == RESP);
  assign byte_mask        = {{8{req_wstrb[3]}}, {8{req_wstrb[2]}},
                             {8{req_wstrb[1]}}, {8{req_wstrb[0]}}};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // The core still holds mem_valid during the ready cycle; do not re-accept it.
        if (bus.mem_valid && !ready_q) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!stall) begin
          if (cnt == 4'd0) state_nxt = RESP;
          else             cnt_nxt   = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lfsr      <= LFSR_SEED;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_wstrb <= 4'd0;
      req_instr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lfsr  <= {lfsr[14:0], lfsr_fb};
      if (accept) begin
        req_addr  <= bus.mem_addr;
        req_wdata <= bus.mem_wdata;
        req_wstrb <= bus.mem_wstrb;
        req_instr <= bus.mem_instr;
      end
    end
  end

  // Completion side effects all land on the edge that raises mem_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q      <= 1'b0;
      rdata_q      <= 32'd0;
      tohost_valid <= 1'b0;
      tohost_data  <= 32'd0;
      err_oob      <= 1'b0;
      fetch_cnt    <= 32'd0;
      store_cnt    <= 32'd0;
    end else begin
      ready_q      <= complete;
      tohost_valid <= 1'b0;
      if (complete) begin
        if (is_write) begin
          store_cnt <= store_cnt + 32'd1;
          if (is_tohost) begin
            tohost_valid <= 1'b1;
            tohost_data  <= req_wdata & byte_mask;
          end else if (!in_ram) begin
            err_oob <= 1'b1;
          end
        end else begin
          if (req_instr) fetch_cnt <= fetch_cnt + 32'd1;
          if (is_tohost) begin
            rdata_q <= 32'd0;
          end else if (in_ram) begin
            rdata_q <= ram[ram_idx];
          end else begin
            rdata_q <= OOB_RDATA;
            err_oob <= 1'b1;
          end
        end
      end
    end
  end

  // RAM is not reset; the backdoor write comes last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (complete && is_write && !is_tohost && in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) ram[ram_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
    if (load_we) ram[load_idx] <= load_data;
  end

endmodule

// File: tb/tb_native_mem_slave.sv
// Three slaves (LATENCY 1, 4, and 2 with stalls) driven one at a time and checked
// every cycle against a transaction-level memory model.
`timescale 1ns/1ps
module tb_native_mem_slave;

  localparam int          MEMW   = 64;
  localparam logic [31:0] TOHOST = 32'h1000_0000;
  localparam logic [31:0] OOB    = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } txn_t;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [2:0]       m_valid, m_instr;
  logic [2:0][31:0] m_addr, m_wdata;
  logic [2:0][3:0]  m_wstrb;
  wire  [2:0]       m_ready;
  wire  [2:0][31:0] m_rdata;
  logic             load_we;
  logic [15:0]      load_addr;
  logic [31:0]      load_data;
  wire  [2:0]       th_valid, err;
  wire  [2:0][31:0] th_data, fcnt, scnt;
  wire  [2:0][1:0]  st;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    native_mem_slave_if bus ();
    assign bus.mem_valid = m_valid[g];
    assign bus.mem_instr = m_instr[g];
    assign bus.mem_addr  = m_addr[g];
    assign bus.mem_wdata = m_wdata[g];
    assign bus.mem_wstrb = m_wstrb[g];
    assign m_ready[g]    = bus.mem_ready;
    assign m_rdata[g]    = bus.mem_rdata;

    native_mem_slave #(
      .MEM_WORDS  (MEMW),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 4 : 2)),
      .STALL_EN   ((g == 2) ? 1 : 0),
      .LFSR_SEED  (16'hACE1),
      .TOHOST_ADDR(TOHOST),
      .OOB_RDATA  (OOB)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .bus         (bus),
      .load_we     (load_we),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .tohost_valid(th_valid[g]),
      .tohost_data (th_data[g]),
      .err_oob     (err[g]),
      .fetch_cnt   (fcnt[g]),
      .store_cnt   (scnt[g]),
      .fsm_state   (st[g])
    );
  end

  // model state: memory image plus the values committed so far per instance
  logic [31:0] mdl_mem [3][MEMW];
  logic [31:0] c_rdata [3];
  logic [31:0] c_fetch [3];
  logic [31:0] c_store [3];
  logic [31:0] c_th    [3];
  logic        c_err   [3];
  logic        prev_ready [3];
  txn_t        exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 2);
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      c_rdata[k] = 32'd0;
      c_fetch[k] = 32'd0;
      c_store[k] = 32'd0;
      c_th[k]    = 32'd0;
      c_err[k]   = 1'b0;
    end
    exp_q.delete();
  endtask

  // Applies one completed transaction to the model; returns whether tohost must pulse.
  task automatic model_commit(input txn_t t, output logic exp_th);
    int          k;
    logic [29:0] w;
    k      = int'(t.k);
    w      = t.addr[31:2];
    exp_th = 1'b0;
    if (t.wstrb != 4'd0) begin
      c_store[k] = c_store[k] + 32'd1;
      if (w == TOHOST[31:2]) begin
        exp_th  = 1'b1;
        c_th[k] = 32'd0;
        for (int b = 0; b < 4; b++)
          if (t.wstrb[b]) c_th[k][8*b +: 8] = t.wdata[8*b +: 8];
      end else if (w < MEMW) begin
        for (int b = 0; b < 4; b++)
          if (t.wstrb[b]) mdl_mem[k][w[5:0]][8*b +: 8] = t.wdata[8*b +: 8];
      end else begin
        c_err[k] = 1'b1;
      end
    end else begin
      if (t.instr) c_fetch[k] = c_fetch[k] + 32'd1;
      if (w == TOHOST[31:2])  c_rdata[k] = 32'd0;
      else if (w < MEMW)      c_rdata[k] = mdl_mem[k][w[5:0]];
      else begin
        c_rdata[k] = OOB;
        c_err[k]   = 1'b1;
      end
    end
  endtask

  // scoreboard: every cycle, every instance
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic exp_th;
      txn_t t;
      exp_th = 1'b0;
      if (m_ready[k]) begin
        check_eq($sformatf("ready_gap%0d", k), 32'(prev_ready[k]), 32'd0);
        if (exp_q.size() == 0 || int'(exp_q[0].k) != k) begin
          n_total++;
          $display("FAIL stray_ready%0d: got ready=1 expected no completion at %0t", k, $time);
        end else begin
          t = exp_q.pop_front();
          model_commit(t, exp_th);
        end
      end
      check_eq($sformatf("tohost_valid%0d", k), 32'(th_valid[k]), 32'(exp_th));
      check_eq($sformatf("rdata%0d", k),        m_rdata[k], c_rdata[k]);
      check_eq($sformatf("fetch_cnt%0d", k),    fcnt[k],    c_fetch[k]);
      check_eq($sformatf("store_cnt%0d", k),    scnt[k],    c_store[k]);
      check_eq($sformatf("tohost_data%0d", k),  th_data[k], c_th[k]);
      check_eq($sformatf("err_oob%0d", k),      32'(err[k]), 32'(c_err[k]));
      prev_ready[k] = m_ready[k];
    end
  end

  // driver tasks
  task automatic bd_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) mdl_mem[k][a[5:0]] = d;
    #1 load_we = 1'b0;
  endtask

  task automatic do_txn(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic instr,
                        output int cycles, output logic [31:0] rdata);
    txn_t t;
    @(negedge clk);
    m_valid[k] = 1'b1;
    m_addr[k]  = addr;
    m_wdata[k] = wdata;
    m_wstrb[k] = wstrb;
    m_instr[k] = instr;
    @(posedge clk);
    t.k = 2'(k); t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.instr = instr;
    exp_q.push_back(t);
    // the slave must ignore anything the bus does after accept
    #1;
    m_addr[k]  = $urandom;
    m_wdata[k] = $urandom;
    m_wstrb[k] = 4'($urandom);
    m_instr[k] = 1'($urandom);
    cycles = 0;
    while (1) begin
      @(posedge clk);
      cycles++;
      #1;
      if (m_ready[k]) break;
      if (cycles >= 64) begin
        n_total++;
        $display("FAIL ready_timeout%0d: got no ready after %0d cycles expected ready", k, cycles);
        break;
      end
    end
    rdata = m_rdata[k];
    @(negedge clk);
    m_valid[k] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int          sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    if (sel == 0)      a = TOHOST | 32'($urandom_range(0, 3));
    else if (sel == 1) a = 32'h0000_0100 + 32'($urandom_range(0, 1023));
    else               a = 32'($urandom_range(0, 255));
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] rd, v;
    int          stall_total;
    m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    load_we = 1'b0; load_addr = 16'd0; load_data = 32'd0;
    for (int k = 0; k < 3; k++) prev_ready[k] = 1'b0;
    reset_model();
    resetn = 1'b1;
    #1 resetn = 1'b0;

    // preload through the backdoor while reset is held, exercising the index wrap
    for (int i = 0; i < MEMW; i++) begin
      v = (i == 0) ? 32'h0140_0093 : ((i == 5) ? 32'd0 : $urandom);
      bd_write(16'(i + MEMW * $urandom_range(0, 3)), v);
    end
    @(negedge clk) resetn = 1'b1;

    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_state%0d", k),  32'(st[k]),       32'd0);
      check_eq($sformatf("rst_ready%0d", k),  32'(m_ready[k]),  32'd0);
      check_eq($sformatf("rst_rdata%0d", k),  m_rdata[k],       32'd0);
      check_eq($sformatf("rst_thv%0d", k),    32'(th_valid[k]), 32'd0);
      check_eq($sformatf("rst_thd%0d", k),    th_data[k],       32'd0);
      check_eq($sformatf("rst_err%0d", k),    32'(err[k]),      32'd0);
      check_eq($sformatf("rst_fetch%0d", k),  fcnt[k],          32'd0);
      check_eq($sformatf("rst_store%0d", k),  scnt[k],          32'd0);
    end

    // fetch of the preloaded ADDI at word 0
    do_txn(0, 32'd0, 32'd0, 4'd0, 1'b1, cyc, rd);
    check_eq("fetch_lat", 32'(cyc), 32'd1);
    check_eq("fetch_rdata", rd, 32'h0140_0093);
    check_eq("fetch_cnt_lit", fcnt[0], 32'd1);

    // partial store then readback
    do_txn(0, 32'd20, 32'hAABB_CCDD, 4'b0101, 1'b0, cyc, rd);
    do_txn(0, 32'd20, 32'd0, 4'd0, 1'b0, cyc, rd);
    check_eq("strobe_rdata", rd, 32'h00BB_00DD);
    check_eq("store_cnt_lit", scnt[0], 32'd1);

    do_txn(1, 32'd12, 32'd0, 4'd0, 1'b0, cyc, rd);
    check_eq("lat4", 32'(cyc), 32'd4);

    // mailbox store and out-of-range read
    do_txn(0, TOHOST, 32'd1, 4'hF, 1'b0, cyc, rd);
    check_eq("tohost_data_lit", th_data[0], 32'd1);
    check_eq("tohost_no_oob", 32'(err[0]), 32'd0);
    do_txn(0, 32'h2000_0000, 32'd0, 4'd0, 1'b0, cyc, rd);
    check_eq("oob_rdata", rd, 32'hDEAD_BEEF);
    check_eq("oob_err", 32'(err[0]), 32'd1);

    // reset lands while a store sits in WAIT: no ready, no write
    v = mdl_mem[1][7];
    @(negedge clk);
    m_valid[1] = 1'b1; m_addr[1] = 32'd28; m_wdata[1] = ~v; m_wstrb[1] = 4'hF; m_instr[1] = 1'b0;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    reset_model();
    #1;
    check_eq("rst_mid_ready", 32'(m_ready[1]), 32'd0);
    check_eq("rst_mid_state", 32'(st[1]), 32'd0);
    m_valid[1] = 1'b0;
    bd_write(16'd9, 32'h1234_5678);
    @(negedge clk) resetn = 1'b1;
    do_txn(1, 32'd28, 32'd0, 4'd0, 1'b0, cyc, rd);
    check_eq("rst_abandon", rd, v);
    do_txn(0, 32'd36, 32'd0, 4'd0, 1'b0, cyc, rd);
    check_eq("bd_in_reset", rd, 32'h1234_5678);

    // randomized traffic on each instance
    stall_total = 0;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 60; n++) begin
        logic [3:0] ws;
        ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        do_txn(k, rand_addr(), $urandom, ws, 1'($urandom), cyc, rd);
        if (k == 2) begin
          check_eq("stall_lat_min", 32'(cyc >= 2), 32'd1);
          stall_total += cyc - 2;
        end else begin
          check_eq($sformatf("lat%0d", k), 32'(cyc), 32'(lat_of(k)));
        end
      end
    end
    check_eq("stall_seen", 32'(stall_total > 0), 32'd1);

    repeat (3) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
